// File: rtl/delay_sched_pkg.sv
// Shared types and defaults for the delay scheduler: FSM encoding and
// the default counter width and delay value offered to integrators.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_RSVD = 2'd2
  } state_t;

  localparam int          DEF_CNT_W   = 26;
  localparam logic [25:0] DEFAULT_DLY = 26'd200;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending bit found searching
// from ptr upward, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant_mask,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  logic [PTR_W-1:0] cand [N_REQ];

  // cand[k] is the k-th index visited in search order
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand[gi] = (int'(ptr) + gi >= N_REQ) ? PTR_W'(int'(ptr) + gi - N_REQ)
                                                  : PTR_W'(int'(ptr) + gi);
    end
  endgenerate

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    // descending scan so the earliest candidate in search order wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pending[cand[k]]) begin
        winner = cand[k];
        valid  = 1'b1;
      end
    end
    grant_mask = valid ? (N_REQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/delay_scheduler.sv
// One countdown timer shared round-robin among N_REQ requesters; each
// job is granted with an ack pulse and finishes with a done pulse.
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PTR_W = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] dly,
  input  logic [N_REQ-1:0]       abort,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [PTR_W-1:0]       grant_id
);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] pending_reg, pending_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [N_REQ-1:0] ack_reg, ack_next;
  logic [N_REQ-1:0] done_reg, done_next;
  logic             busy_reg, busy_next;
  logic [PTR_W-1:0] gid_reg, gid_next;

  logic [CNT_W-1:0] dly_arr [N_REQ];
  logic [N_REQ-1:0] arb_mask, grant_mask;
  logic [PTR_W-1:0] arb_winner;
  logic             arb_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dly
      assign dly_arr[gi] = dly[gi*CNT_W +: CNT_W];
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .pending    (pending_reg),
    .ptr        (ptr_reg),
    .grant_mask (arb_mask),
    .winner     (arb_winner),
    .valid      (arb_valid)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gid_next   = gid_reg;
    ack_next   = '0;
    done_next  = '0;
    grant_mask = '0;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          grant_mask = arb_mask;
          cnt_next   = dly_arr[arb_winner];
          gid_next   = arb_winner;
          ack_next   = arb_mask;
          ptr_next   = (arb_winner == PTR_W'(N_REQ - 1)) ? '0 : arb_winner + 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // abort of the owner wins over an expiring count
        if (abort[gid_reg]) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          done_next  = N_REQ'(1) << gid_reg;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    pending_next = (pending_reg & ~grant_mask & ~abort) | (req & ~abort);
    busy_next    = (state_next == RUN);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      cnt_reg     <= '0;
      ptr_reg     <= '0;
      ack_reg     <= '0;
      done_reg    <= '0;
      busy_reg    <= 1'b0;
      gid_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      gid_reg     <= gid_next;
    end
  end

  assign ack      = ack_reg;
  assign done     = done_reg;
  assign busy     = busy_reg;
  assign grant_id = gid_reg;

endmodule
